// File: rtl/pe_feeder_ctrl.sv
// Initiator side of the PE load/MAC interface: loads a weight vector into
// the PE, streams operands through valid/dvalid and captures the final dout.
module pe_feeder_ctrl #(
    parameter int VLEN    = 16,
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 6,
    parameter int MAWIDTH = 7
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [DWIDTH-1:0]  result,
    output logic [MAWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0]  mem_rdata,
    output logic               pe_aresetn,
    output logic               pe_we,
    output logic [AWIDTH-1:0]  pe_addr,
    output logic [DWIDTH-1:0]  pe_din,
    output logic [DWIDTH-1:0]  pe_ain,
    output logic               pe_valid,
    input  logic               pe_dvalid,
    input  logic [DWIDTH-1:0]  pe_dout
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LOAD, S_FETCH, S_ISSUE, S_WAIT, S_DONE
    } state_t;

    localparam logic [AWIDTH-1:0]  LAST   = AWIDTH'(VLEN - 1);
    localparam logic [MAWIDTH-1:0] OPBASE = MAWIDTH'(VLEN);

    state_t               r_state, w_state;
    logic [AWIDTH-1:0]    r_cnt, w_cnt;
    logic                 r_tail, w_tail;
    logic                 r_dv_hold, w_dv_hold;
    logic                 r_busy, w_busy;
    logic                 r_done, w_done;
    logic [DWIDTH-1:0]    r_result, w_result;
    logic [MAWIDTH-1:0]   r_mem_addr, w_mem_addr;
    logic                 r_pe_rstn, w_pe_rstn;
    logic                 r_pe_we, w_pe_we;
    logic [AWIDTH-1:0]    r_pe_addr, w_pe_addr;
    logic [DWIDTH-1:0]    r_pe_din, w_pe_din;
    logic [DWIDTH-1:0]    r_pe_ain, w_pe_ain;
    logic                 r_pe_valid, w_pe_valid;
    logic                 w_dv;

    assign w_dv = pe_dvalid | r_dv_hold;

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_tail     = r_tail;
        w_dv_hold  = r_dv_hold;
        w_result   = r_result;
        w_mem_addr = r_mem_addr;
        w_pe_addr  = r_pe_addr;
        w_pe_din   = r_pe_din;
        w_pe_ain   = r_pe_ain;
        w_pe_we    = 1'b0;
        w_pe_valid = 1'b0;
        w_done     = 1'b0;
        w_pe_rstn  = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state    = S_CLR;
                    w_pe_rstn  = 1'b0;
                    w_mem_addr = '0;
                end
            end
            S_CLR: begin
                w_state    = S_LOAD;
                w_cnt      = '0;
                w_tail     = 1'b0;
                w_mem_addr = MAWIDTH'(1);
            end
            S_LOAD: begin
                if (r_tail) begin
                    w_state = S_FETCH;
                    w_cnt   = '0;
                end else begin
                    w_pe_we   = 1'b1;
                    w_pe_addr = r_cnt;
                    w_pe_din  = mem_rdata;
                    // Address stops at the first operand so FETCH sees it.
                    if (r_cnt == LAST) begin
                        w_tail = 1'b1;
                    end else begin
                        w_cnt      = r_cnt + AWIDTH'(1);
                        w_mem_addr = MAWIDTH'(r_cnt) + MAWIDTH'(2);
                    end
                end
            end
            S_FETCH: begin
                w_state    = S_ISSUE;
                w_pe_ain   = mem_rdata;
                w_pe_addr  = r_cnt;
                w_pe_valid = 1'b1;
                w_dv_hold  = 1'b0;
            end
            S_ISSUE: begin
                w_state = S_WAIT;
                if (pe_dvalid) begin
                    w_dv_hold = 1'b1;
                end
                // Prefetch the next operand while the MAC is in flight.
                if (r_cnt != LAST) begin
                    w_mem_addr = OPBASE + MAWIDTH'(r_cnt) + MAWIDTH'(1);
                end
            end
            S_WAIT: begin
                if (w_dv) begin
                    w_dv_hold = 1'b0;
                    if (r_cnt == LAST) begin
                        w_result = pe_dout;
                        w_state  = S_DONE;
                        w_done   = 1'b1;
                    end else begin
                        w_cnt   = r_cnt + AWIDTH'(1);
                        w_state = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_tail     <= 1'b0;
            r_dv_hold  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_mem_addr <= '0;
            r_pe_rstn  <= 1'b0;
            r_pe_we    <= 1'b0;
            r_pe_addr  <= '0;
            r_pe_din   <= '0;
            r_pe_ain   <= '0;
            r_pe_valid <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_tail     <= w_tail;
            r_dv_hold  <= w_dv_hold;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_result   <= w_result;
            r_mem_addr <= w_mem_addr;
            r_pe_rstn  <= w_pe_rstn;
            r_pe_we    <= w_pe_we;
            r_pe_addr  <= w_pe_addr;
            r_pe_din   <= w_pe_din;
            r_pe_ain   <= w_pe_ain;
            r_pe_valid <= w_pe_valid;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign result     = r_result;
    assign mem_addr   = r_mem_addr;
    assign pe_aresetn = r_pe_rstn;
    assign pe_we      = r_pe_we;
    assign pe_addr    = r_pe_addr;
    assign pe_din     = r_pe_din;
    assign pe_ain     = r_pe_ain;
    assign pe_valid   = r_pe_valid;

endmodule
